// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, counter-width helper and forwarding-mode enum
// for the decode-stage hazard scoreboard.
//   - *_DEF localparams : default parameter values for hazard_scoreboard
//   - fwd_mode_e        : full-latency stalls vs. load-use-only stalls
//   - cnt_width()       : bits needed to hold max(WB_LAT, LOAD_USE_DIST)
package hazard_pkg;

    localparam int REG_ADDR_W_DEF    = 4;
    localparam int WB_LAT_DEF        = 2;
    localparam int LOAD_USE_DIST_DEF = 1;
    localparam int FWD_EN_DEF        = 0;
    localparam int STAT_W_DEF        = 32;

    typedef enum logic {
        MODE_STALL_ALL = 1'b0,
        MODE_LOAD_USE  = 1'b1
    } fwd_mode_e;

    // Width of one countdown entry; never less than one bit so a degenerate
    // configuration still elaborates.
    function automatic int cnt_width(input int wb_lat, input int load_use_dist);
        int m;
        m = (wb_lat > load_use_dist) ? wb_lat : load_use_dist;
        return (m + 1 <= 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// sb_counter: one per-register countdown entry.
//   clk, rst_n   : clock, async active-low reset (clears the entry)
//   load/load_val       : new pending-write distance from an accepted issue
//   restore/restore_val : undo of a squashed issue (highest priority)
//   cnt          : cycles until the register's value is readable
// Priority: restore, then load, then the free-running decrement to zero.
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         restore,
    input  logic [W-1:0] restore_val,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (restore)
            cnt <= restore_val;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard between decode and ID/EX.
//   clk, rst_n           : clock, async active-low reset
//   issue_valid          : decoded instruction present
//   src1, src2, two_src  : source operands (src2 only when two_src)
//   dst, wb_en, mem_read : destination, writes-dst flag, load flag
//   flush                : squash decode and the instruction issued last cycle
//   hazard               : stall decode (combinational)
//   issue_fire           : instruction accepted into ID/EX this cycle
//   busy_any             : some register still has a pending write
//   stall_count          : saturating count of hazard cycles
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W    = REG_ADDR_W_DEF,
    parameter int WB_LAT        = WB_LAT_DEF,
    parameter int LOAD_USE_DIST = LOAD_USE_DIST_DEF,
    parameter int FWD_EN        = FWD_EN_DEF,
    parameter int STAT_W        = STAT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  two_src,
    input  logic [REG_ADDR_W-1:0] dst,
    input  logic                  wb_en,
    input  logic                  mem_read,
    input  logic                  flush,
    output logic                  hazard,
    output logic                  issue_fire,
    output logic                  busy_any,
    output logic [STAT_W-1:0]     stall_count
);

    localparam int        NUM_REGS = 2 ** REG_ADDR_W;
    localparam int        CNT_W    = cnt_width(WB_LAT, LOAD_USE_DIST);
    localparam fwd_mode_e MODE     = (FWD_EN != 0) ? MODE_LOAD_USE : MODE_STALL_ALL;
    localparam logic [CNT_W-1:0] WB_VAL = CNT_W'(WB_LAT);
    localparam logic [CNT_W-1:0] LU_VAL = CNT_W'(LOAD_USE_DIST);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            busy_vec;

    logic                  wr_go;
    logic [CNT_W-1:0]      cur, cur_m1, newval, load_val;
    logic                  restore_go;
    logic [CNT_W-1:0]      restore_val;

    logic                  last_valid;
    logic [REG_ADDR_W-1:0] last_dst;
    logic [CNT_W-1:0]      last_prev;

    // Sources are compared against the counters before this cycle's write,
    // so an instruction reading its own destination never self-stalls.
    assign hazard     = issue_valid & ~flush &
                        (busy_vec[src1] | (two_src & busy_vec[src2]));
    assign issue_fire = issue_valid & ~flush & ~hazard;
    assign wr_go      = issue_fire & wb_en;
    assign busy_any   = |busy_vec;

    // The older pending write keeps its remaining distance if it is longer.
    assign cur      = cnt[dst];
    assign cur_m1   = (cur == '0) ? '0 : cur - 1'b1;
    assign newval   = (MODE == MODE_LOAD_USE) ? (mem_read ? LU_VAL : '0) : WB_VAL;
    assign load_val = (newval > cur_m1) ? newval : cur_m1;

    // last_prev was sampled one edge before the squashed issue landed; two
    // decrements have elapsed by the time the restore lands.
    assign restore_go  = flush & last_valid;
    assign restore_val = (last_prev > CNT_W'(1)) ? last_prev - CNT_W'(2) : '0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ent
        assign busy_vec[g] = (cnt[g] != '0);

        sb_counter #(.W(CNT_W)) u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .load        (wr_go && (dst == REG_ADDR_W'(g))),
            .load_val    (load_val),
            .restore     (restore_go && (last_dst == REG_ADDR_W'(g))),
            .restore_val (restore_val),
            .cnt         (cnt[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_valid  <= 1'b0;
            last_dst    <= '0;
            last_prev   <= '0;
            stall_count <= '0;
        end else begin
            last_valid <= wr_go;
            if (wr_go) begin
                last_dst  <= dst;
                last_prev <= cur;
            end
            if (hazard && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: three scoreboard configurations share one stimulus
// stream: A (FWD_EN=0), B (FWD_EN=1), C (FWD_EN=0, STAT_W=4). The reference
// model tracks, per register, the absolute cycle at which its value becomes
// readable; expected outputs are queued by the driver and checked by a
// separate negedge monitor.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic [3:0] src1 = '0, src2 = '0, dst = '0;
    logic       two_src = 1'b0, wb_en = 1'b0, mem_read = 1'b0, flush = 1'b0;

    logic        hz_a, hz_b, hz_c, fi_a, fi_b, fi_c, ba_a, ba_b, ba_c;
    logic [31:0] sc_a, sc_b;
    logic [3:0]  sc_c;

    always #5 clk = ~clk;

    hazard_scoreboard #(.FWD_EN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .dst(dst), .wb_en(wb_en), .mem_read(mem_read), .flush(flush),
        .hazard(hz_a), .issue_fire(fi_a), .busy_any(ba_a), .stall_count(sc_a));
    hazard_scoreboard #(.FWD_EN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .dst(dst), .wb_en(wb_en), .mem_read(mem_read), .flush(flush),
        .hazard(hz_b), .issue_fire(fi_b), .busy_any(ba_b), .stall_count(sc_b));
    hazard_scoreboard #(.FWD_EN(0), .STAT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .dst(dst), .wb_en(wb_en), .mem_read(mem_read), .flush(flush),
        .hazard(hz_c), .issue_fire(fi_c), .busy_any(ba_c), .stall_count(sc_c));

    typedef struct packed {
        logic [2:0]       hz;
        logic [2:0]       fire;
        logic [2:0]       busy;
        logic [2:0][31:0] sc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    longint cyc = 0;

    // Reference model state, per configuration k.
    longint rdy   [3][16];
    bit     lastv [3];
    int     ldst  [3];
    longint lprev [3];
    longint scnt  [3];
    int     cfg_fwd [3] = '{0, 1, 0};
    longint cfg_max [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 16; r++) rdy[k][r] = 0;
            lastv[k] = 0; ldst[k] = 0; lprev[k] = 0; scnt[k] = 0;
        end
    endtask

    // Drive one cycle's inputs (just after the edge), queue the expected
    // outputs for the monitor, then advance the model across the next edge.
    task automatic step(input bit rn, input bit iv, input int s1, input int s2,
                        input bit ts, input int d, input bit wb, input bit mr,
                        input bit fl);
        exp_t e;
        rst_n = rn; issue_valid = iv; src1 = 4'(s1); src2 = 4'(s2);
        two_src = ts; dst = 4'(d); wb_en = wb; mem_read = mr; flush = fl;
        if (!rn) model_reset();
        e = '0;
        for (int k = 0; k < 3; k++) begin
            bit b1, b2, any, h, f;
            longint nv;
            b1 = rdy[k][s1] > cyc;
            b2 = rdy[k][s2] > cyc;
            any = 0;
            for (int r = 0; r < 16; r++) if (rdy[k][r] > cyc) any = 1;
            h = iv && !fl && (b1 || (ts && b2));
            f = iv && !fl && !h;
            e.hz[k] = h; e.fire[k] = f; e.busy[k] = any; e.sc[k] = 32'(scnt[k]);
            if (rn) begin
                if (fl && lastv[k]) rdy[k][ldst[k]] = lprev[k];
                if (f && wb) begin
                    lastv[k] = 1; ldst[k] = d; lprev[k] = rdy[k][d];
                    nv = (cfg_fwd[k] != 0) ? (mr ? 1 : 0) : 2;
                    if (cyc + 1 + nv > rdy[k][d]) rdy[k][d] = cyc + 1 + nv;
                end else begin
                    lastv[k] = 0;
                end
                if (h && scnt[k] < cfg_max[k]) scnt[k]++;
            end
        end
        q.push_back(e);
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input int k, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cfg%0d cyc=%0d got=%0d expected=%0d", nm, k, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("hazard",      0, hz_a, e.hz[0]);
            chk("hazard",      1, hz_b, e.hz[1]);
            chk("hazard",      2, hz_c, e.hz[2]);
            chk("issue_fire",  0, fi_a, e.fire[0]);
            chk("issue_fire",  1, fi_b, e.fire[1]);
            chk("issue_fire",  2, fi_c, e.fire[2]);
            chk("busy_any",    0, ba_a, e.busy[0]);
            chk("busy_any",    1, ba_b, e.busy[1]);
            chk("busy_any",    2, ba_c, e.busy[2]);
            chk("stall_count", 0, sc_a, e.sc[0]);
            chk("stall_count", 1, sc_b, e.sc[1]);
            chk("stall_count", 2, {28'd0, sc_c}, e.sc[2]);
        end
    end

    initial begin
        model_reset();
        @(posedge clk); #1;
        // reset with a reader presented: no hazard, fire follows issue_valid
        step(0, 1, 3, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0, 0, 0, 0);
        // full-latency producer r5 then dependent reader held until it fires
        step(1, 1, 0, 0, 0, 5, 1, 0, 0);
        repeat (4) step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        // load-use on src2, then ALU producer, then src2 not a real operand
        step(1, 1, 0, 0, 0, 2, 1, 1, 0);
        repeat (3) step(1, 1, 0, 2, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 2, 1, 0, 0);
        repeat (3) step(1, 1, 0, 2, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 2, 1, 1, 0);
        repeat (3) step(1, 1, 0, 2, 0, 0, 0, 0, 0);
        // r7 written, idle, rewritten, rewrite squashed, then r7 reader
        step(1, 1, 0, 0, 0, 7, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 7, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) step(1, 1, 7, 0, 0, 0, 0, 0, 0);
        // pending load pins hazard, flush masks it
        step(1, 1, 0, 0, 0, 3, 1, 1, 0);
        step(1, 1, 3, 0, 0, 0, 0, 0, 1);
        repeat (3) step(1, 1, 3, 0, 0, 0, 0, 0, 0);
        // >20 stall cycles in the full-latency configs: saturates 4-bit counter
        repeat (11) begin
            step(1, 1, 0, 0, 0, 5, 1, 0, 0);
            repeat (3) step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        end
        // reset dropped in the middle of a stall cycle
        step(1, 1, 0, 0, 0, 5, 1, 1, 0);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        // randomized traffic on a small register window to provoke hazards
        repeat (600) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                 $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 7) == 0);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
